nmos_pass_bank: RTL
===================

NMOS_PASS_BANK -- requirements
Module: nmos_pass_bank

Interface
REQ-001 SHALL have parameter WIDTH, 1, bits per channel.
REQ-002 SHALL have parameter CHANS, 1, number of independent pass channels.
REQ-003 SHALL have parameter DECAY_CYC, 16, gate-low clock edges before a stored node loses charge (legal range >= 1).
REQ-004 SHALL have parameter DECAY_VAL, 0, WIDTH-bit value a discharged node presents.
REQ-005 SHALL have port main_clk  input  1  simulation main clock; all state updates on its rising edge.
REQ-006 SHALL have port main_rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port G  input  CHANS  per-channel gate; bit c gates channel c.
REQ-008 SHALL have port D  input  CHANS*WIDTH  drain inputs; channel c at bits [c*WIDTH +: WIDTH].
REQ-009 SHALL have port S  output  CHANS*WIDTH  source outputs, same packing as D, registered.
REQ-010 SHALL have port charged  output  CHANS  per-channel flag; 1 = node holds a driven value.

Function
REQ-011 SHALL treat channels as fully independent; no channel's state depends on another's G or D.
REQ-012 SHALL, on an edge with G[c]=1, load S[c] <= D[c], set charged[c] <= 1, clear age[c] <= 0 (one-edge latency, D sampled at that edge).
REQ-013 SHALL, on an edge with G[c]=0 and charged[c]=1, increment age[c]; when age[c]+1 == DECAY_CYC, set S[c] <= DECAY_VAL, charged[c] <= 0 on that same edge.
REQ-014 SHALL, with G[c]=0 and charged[c]=0, hold S[c]=DECAY_VAL and age[c] unchanged (no wrap, no further counting).
REQ-015 SHALL give G[c]=1 priority over decay when both apply on the same edge (load wins, age restarts).
REQ-016 SHALL thus, for a load at edge k followed by G low, hold S[c] through edges k+1..k+DECAY_CYC-1 and present DECAY_VAL after edge k+DECAY_CYC.
REQ-017 SHALL size age[c] as clog2(DECAY_CYC+1) bits; counter never exceeds DECAY_CYC-1 while charged.
REQ-018 SHALL, with G[c] held high continuously, track D[c] every edge and never decay.
REQ-019 SHALL keep S and charged purely registered; no combinational path from G or D to outputs.

Reset
REQ-020 SHALL, on an edge with main_rst_n=0, set every S[c]=DECAY_VAL, charged[c]=0, age[c]=0, regardless of G.
REQ-021 SHALL let reset override any in-progress load or decay; first load possible on the first edge with main_rst_n=1 and G[c]=1.

Configuration
REQ-022 SHALL honour macro NMOS_PASS_DECAY_EN: defined -> REQ-013/016/017 decay behaviour active; undefined -> no age counters synthesised, a loaded node holds indefinitely, charged[c] stays 1 from first load until reset, DECAY_CYC ignored.

Structure
REQ-023 SHALL place in shared package nmos_pkg: default DECAY_CYC/DECAY_VAL constants and the age-width function used by REQ-017.
REQ-024 SHALL implement one channel as sub-module nmos_pass_cell (WIDTH, DECAY_CYC, DECAY_VAL), instantiated CHANS times by generate in nmos_pass_bank.

Verification (WIDTH=8, CHANS=4, DECAY_CYC=5, DECAY_VAL=8'h00, NMOS_PASS_DECAY_EN defined unless stated)
REQ-025 SHALL check reset: main_rst_n=0 one edge with G=4'hF, D=32'hFFFFFFFF -> S=32'h0, charged=4'h0 after edge.
REQ-026 SHALL check load/decay: G[0] pulse at edge k with D[0]=8'hA5, then G[0]=0 -> S[0]=8'hA5 after edges k..k+4, 8'h00 and charged[0]=0 after edge k+5.
REQ-027 SHALL check refresh race: G[1] reloads 8'h3C exactly at edge k+5 of a prior load -> S[1]=8'h3C, charged[1]=1, decay restarts (S[1]=8'h00 after k+10).
REQ-028 SHALL check independence: G=4'b0101, D channels 11/22/33/44 -> S[0]=8'h11, S[2]=8'h33, S[1]/S[3] unchanged.
REQ-029 SHALL check mid-operation reset: main_rst_n=0 at edge k+2 after load -> S[c]=8'h00, charged=0; G high on k+3 reloads normally.
REQ-030 SHALL check macro off: NMOS_PASS_DECAY_EN undefined, load 8'h5A then G low 100 edges -> S[0]=8'h5A, charged[0]=1 throughout.

Source files
------------

// File: rtl/nmos_pkg.sv
// nmos_pkg: shared defaults and the age-counter width helper for the NMOS pass bank
package nmos_pkg;
  localparam int DECAY_CYC_DEF = 16;
  localparam int DECAY_VAL_DEF = 0;
  function automatic int age_w(input int decay_cyc);
    return $clog2(decay_cyc + 1);
  endfunction
endpackage

// File: rtl/nmos_pass_cell.sv
// nmos_pass_cell: one pass-transistor storage node with optional charge decay
// Ports: main_clk clock, main_rst_n sync active-low reset, g gate, d drain in,
//        s registered source out, charged = node holds a driven value.
// Macro NMOS_PASS_DECAY_EN: defined -> node discharges to DECAY_VAL after
//        DECAY_CYC gate-low edges; undefined -> node holds until reset.
module nmos_pass_cell
  import nmos_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               DECAY_CYC = DECAY_CYC_DEF,
  parameter logic [WIDTH-1:0] DECAY_VAL = WIDTH'(DECAY_VAL_DEF)
) (
  input  logic             main_clk,
  input  logic             main_rst_n,
  input  logic             g,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] s,
  output logic             charged
);
  if (DECAY_CYC < 1) begin : g_chk
    $error("DECAY_CYC must be >= 1");
  end
`ifdef NMOS_PASS_DECAY_EN
  localparam int            AW   = age_w(DECAY_CYC);
  localparam logic [AW-1:0] LAST = AW'(DECAY_CYC - 1);
  logic [AW-1:0] age;
  // age stops at DECAY_CYC once discharged because only charged nodes count
  always_ff @(posedge main_clk)
    if (!main_rst_n) begin
      s       <= DECAY_VAL;
      charged <= 1'b0;
      age     <= '0;
    end else if (g) begin
      s       <= d;
      charged <= 1'b1;
      age     <= '0;
    end else if (charged) begin
      age     <= age + 1'b1;
      charged <= age != LAST;
      s       <= age == LAST ? DECAY_VAL : s;
    end
`else
  always_ff @(posedge main_clk)
    if (!main_rst_n) begin
      s       <= DECAY_VAL;
      charged <= 1'b0;
    end else if (g) begin
      s       <= d;
      charged <= 1'b1;
    end
`endif
endmodule

// File: rtl/nmos_pass_bank.sv
// nmos_pass_bank: CHANS independent registered pass-transistor storage nodes
// Ports: main_clk clock, main_rst_n sync active-low reset, G per-channel gate,
//        D packed drains (channel c at [c*WIDTH +: WIDTH]), S packed sources
//        (same packing, registered), charged per-channel node-valid flag.
// Macro NMOS_PASS_DECAY_EN enables charge decay after DECAY_CYC gate-low edges.
module nmos_pass_bank
  import nmos_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               CHANS     = 1,
  parameter int               DECAY_CYC = DECAY_CYC_DEF,
  parameter logic [WIDTH-1:0] DECAY_VAL = WIDTH'(DECAY_VAL_DEF)
) (
  input  logic                   main_clk,
  input  logic                   main_rst_n,
  input  logic [CHANS-1:0]       G,
  input  logic [CHANS*WIDTH-1:0] D,
  output logic [CHANS*WIDTH-1:0] S,
  output logic [CHANS-1:0]       charged
);
  for (genvar c = 0; c < CHANS; c++) begin : g_ch
    nmos_pass_cell #(
      .WIDTH    (WIDTH),
      .DECAY_CYC(DECAY_CYC),
      .DECAY_VAL(DECAY_VAL)
    ) u_cell (
      .main_clk  (main_clk),
      .main_rst_n(main_rst_n),
      .g         (G[c]),
      .d         (D[c*WIDTH +: WIDTH]),
      .s         (S[c*WIDTH +: WIDTH]),
      .charged   (charged[c])
    );
  end
endmodule
